// File: rtl/gpio_in_cond_if.sv
// gpio_in_cond_if: pad inputs, interrupt controls and conditioned outputs for gpio_in_cond
interface gpio_in_cond_if #(
  parameter int GPIO_DATA_WIDTH = 8,
  parameter int DB_CNT_WIDTH    = 4
);
  logic [GPIO_DATA_WIDTH-1:0] gpio_pin_in;
  logic [GPIO_DATA_WIDTH-1:0] n_gpio_pin_oe;
  logic [DB_CNT_WIDTH-1:0]    db_limit;
  logic [GPIO_DATA_WIDTH-1:0] irq_rise_en;
  logic [GPIO_DATA_WIDTH-1:0] irq_fall_en;
  logic [GPIO_DATA_WIDTH-1:0] irq_clr;
  logic [GPIO_DATA_WIDTH-1:0] gpio_in_db;
  logic [GPIO_DATA_WIDTH-1:0] irq_status;
  logic                       irq;
  modport master (
    output gpio_pin_in, n_gpio_pin_oe, db_limit, irq_rise_en, irq_fall_en, irq_clr,
    input  gpio_in_db, irq_status, irq
  );
  modport slave (
    input  gpio_pin_in, n_gpio_pin_oe, db_limit, irq_rise_en, irq_fall_en, irq_clr,
    output gpio_in_db, irq_status, irq
  );
endinterface

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: per-pin synchroniser, debouncer and sticky edge-interrupt flags
module gpio_in_cond #(
  parameter int GPIO_DATA_WIDTH = 8,
  parameter int DB_CNT_WIDTH    = 4
) (
  input logic          pclk,
  input logic          p_reset,
  gpio_in_cond_if.slave bus
);
  for (genvar i = 0; i < GPIO_DATA_WIDTH; i++) begin : g_pin
    logic                    s1, s2, db, st, commit, set;
    logic [DB_CNT_WIDTH-1:0] cnt;
    // >= rather than == so a threshold lowered mid-count still commits
    assign commit = (s2 != db) && (cnt >= bus.db_limit);
    assign set    = commit && bus.n_gpio_pin_oe[i] && (s2 ? bus.irq_rise_en[i] : bus.irq_fall_en[i]);
    always_ff @(posedge pclk or posedge p_reset)
      if (p_reset) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        db  <= 1'b0;
        st  <= 1'b0;
        cnt <= '0;
      end else begin
        s1  <= bus.gpio_pin_in[i];
        s2  <= s1;
        cnt <= (s2 == db || commit) ? '0 : cnt + 1'b1;
        db  <= commit ? s2 : db;
        st  <= set | (st & ~bus.irq_clr[i]);
      end
    assign bus.gpio_in_db[i] = db;
    assign bus.irq_status[i] = st;
  end
  assign bus.irq = |bus.irq_status;
endmodule

// File: tb/tb_gpio_in_cond.sv
// tb_gpio_in_cond: scoreboard bench with a behavioural debounce/interrupt model
module tb_gpio_in_cond;
  localparam int W = 8;
  localparam int C = 4;
  logic pclk = 1'b0;
  logic p_reset;
  always #5 pclk = ~pclk;
  gpio_in_cond_if #(.GPIO_DATA_WIDTH(W), .DB_CNT_WIDTH(C)) bus ();
  gpio_in_cond #(.GPIO_DATA_WIDTH(W), .DB_CNT_WIDTH(C)) dut (.pclk(pclk), .p_reset(p_reset), .bus(bus));
  typedef struct { logic [W-1:0] db; logic [W-1:0] st; } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  bit m_s1[W], m_s2[W], m_db[W], m_st[W];
  int disagree[W];
  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic logic [W-1:0] pack(bit v[W]);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[i];
    return r;
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < W; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_st[i] = 0; disagree[i] = 0;
    end
  endfunction
  // the model tracks how long the synchronised level has disagreed with the output
  task automatic step();
    exp_t e;
    for (int i = 0; i < W; i++) begin
      bit fire = 0;
      if (m_s2[i] != m_db[i]) begin
        if (disagree[i] >= int'(bus.db_limit)) begin
          fire = bus.n_gpio_pin_oe[i] && (m_s2[i] ? bus.irq_rise_en[i] : bus.irq_fall_en[i]);
          m_db[i] = m_s2[i];
          disagree[i] = 0;
        end else disagree[i]++;
      end else disagree[i] = 0;
      m_st[i] = fire ? 1'b1 : (bus.irq_clr[i] ? 1'b0 : m_st[i]);
      m_s2[i] = m_s1[i];
      m_s1[i] = bus.gpio_pin_in[i];
    end
    e.db = pack(m_db);
    e.st = pack(m_st);
    q.push_back(e);
    @(posedge pclk);
    @(negedge pclk);
    #1;
  endtask
  always @(negedge pclk)
    if (!p_reset && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("gpio_in_db", bus.gpio_in_db, e.db);
      chk("irq_status", bus.irq_status, e.st);
      chk("irq", {{(W-1){1'b0}}, bus.irq}, {{(W-1){1'b0}}, |e.st});
    end
  task automatic do_reset();
    p_reset = 1'b1;
    #2;
    chk("reset gpio_in_db", bus.gpio_in_db, '0);
    chk("reset irq_status", bus.irq_status, '0);
    chk("reset irq", {{(W-1){1'b0}}, bus.irq}, '0);
    model_reset();
    #1;
    p_reset = 1'b0;
  endtask
  task automatic idle_inputs();
    bus.gpio_pin_in = '0;
    bus.n_gpio_pin_oe = '1;
    bus.db_limit = '0;
    bus.irq_rise_en = '1;
    bus.irq_fall_en = '1;
    bus.irq_clr = '0;
  endtask
  initial begin
    p_reset = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge pclk);
    #1;
    do_reset();
    // immediate commit with no debounce
    bus.gpio_pin_in[0] = 1'b1;
    repeat (3) step();
    chk("nodb db0", {7'b0, bus.gpio_in_db[0]}, 8'd1);
    chk("nodb irq", {7'b0, bus.irq}, 8'd1);
    // glitch shorter than threshold, then a long pulse
    idle_inputs();
    do_reset();
    bus.db_limit = 4'd4;
    bus.gpio_pin_in[2] = 1'b1;
    repeat (3) step();
    bus.gpio_pin_in[2] = 1'b0;
    repeat (5) step();
    chk("glitch db2", {7'b0, bus.gpio_in_db[2]}, 8'd0);
    chk("glitch st2", {7'b0, bus.irq_status[2]}, 8'd0);
    bus.gpio_pin_in[2] = 1'b1;
    repeat (6) step();
    chk("long E6 db2", {7'b0, bus.gpio_in_db[2]}, 8'd0);
    step();
    chk("long E7 db2", {7'b0, bus.gpio_in_db[2]}, 8'd1);
    // output-mode pin updates the value but never flags
    idle_inputs();
    do_reset();
    bus.n_gpio_pin_oe[5] = 1'b0;
    bus.gpio_pin_in[5] = 1'b1;
    repeat (4) step();
    bus.gpio_pin_in[5] = 1'b0;
    repeat (4) step();
    chk("oe db5", {7'b0, bus.gpio_in_db[5]}, 8'd0);
    chk("oe st5", {7'b0, bus.irq_status[5]}, 8'd0);
    // clear coinciding with a set loses; a later clear wins
    idle_inputs();
    do_reset();
    bus.gpio_pin_in[1] = 1'b1;
    repeat (2) step();
    bus.irq_clr[1] = 1'b1;
    step();
    chk("setwins st1", {7'b0, bus.irq_status[1]}, 8'd1);
    step();
    bus.irq_clr = '0;
    chk("clr st1", {7'b0, bus.irq_status[1]}, 8'd0);
    chk("clr irq", {7'b0, bus.irq}, 8'd0);
    // disabling enables keeps a set flag
    bus.gpio_pin_in[1] = 1'b0;
    repeat (3) step();
    bus.irq_fall_en = '0;
    bus.irq_rise_en = '0;
    step();
    chk("sticky st1", {7'b0, bus.irq_status[1]}, 8'd1);
    // threshold lowered mid-count
    idle_inputs();
    do_reset();
    bus.db_limit = 4'd15;
    bus.gpio_pin_in[3] = 1'b1;
    repeat (12) step();
    chk("lim15 db3", {7'b0, bus.gpio_in_db[3]}, 8'd0);
    bus.db_limit = 4'd3;
    step();
    chk("lim3 db3", {7'b0, bus.gpio_in_db[3]}, 8'd1);
    // reset mid-count restarts the debounce
    idle_inputs();
    do_reset();
    bus.db_limit = 4'd4;
    bus.gpio_pin_in[7] = 1'b1;
    repeat (4) step();
    do_reset();
    repeat (6) step();
    chk("rst E6 db7", {7'b0, bus.gpio_in_db[7]}, 8'd0);
    step();
    chk("rst E7 db7", {7'b0, bus.gpio_in_db[7]}, 8'd1);
    chk("rst E7 st7", {7'b0, bus.irq_status[7]}, 8'd1);
    // randomized traffic
    idle_inputs();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(5) == 0) bus.gpio_pin_in[i] = ~bus.gpio_pin_in[i];
      if ($urandom_range(15) == 0) bus.db_limit = C'($urandom_range(6));
      if ($urandom_range(31) == 0) bus.db_limit = C'($urandom_range(15));
      if ($urandom_range(7) == 0) begin
        bus.irq_rise_en = W'($urandom);
        bus.irq_fall_en = W'($urandom);
        bus.n_gpio_pin_oe = W'($urandom);
      end
      bus.irq_clr = ($urandom_range(3) == 0) ? W'($urandom) : '0;
      if ($urandom_range(149) == 0) do_reset();
      step();
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard drain: %0d left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
